// File: rtl/shift_reg_line_ctrl.sv
// Packs IN_W-bit beats into BEATS-beat lines (first beat in the MSBs), zero-padding early-closed lines.
// Optional LINE_STATS_EN adds saturating line_count/pad_count outputs.
module shift_reg_line_ctrl #(
   parameter int IN_W  = 256,
   parameter int BEATS = 2,
   parameter int CNT_W = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         in_data,
   input  logic                    in_last,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [IN_W*BEATS-1:0]   out_data,
   output logic                    out_last,
   output logic [CNT_W-1:0]        out_beats,
   output logic                    busy
`ifdef LINE_STATS_EN
   ,
   output logic [31:0]             line_count,
   output logic [31:0]             pad_count
`endif
);

   localparam int OUT_W = IN_W * BEATS;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);
   localparam logic [CNT_W-1:0] BEATS_C  = CNT_W'(BEATS);

   typedef enum logic {FILL, HOLD} state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [OUT_W-1:0]   line_reg, line_next;
   logic               last_reg, last_next;
   logic [CNT_W-1:0]   beats_reg, beats_next;

   logic               accept;
   logic               handoff;
   logic               flush_eff;
   logic [CNT_W-1:0]   base_cnt;
   logic [CNT_W-1:0]   close_beats;
   logic [OUT_W-1:0]   shifted;

   // MSB-align a line holding n real beats; constant shifts only, selected by n.
   function automatic logic [OUT_W-1:0] pad_line(input logic [OUT_W-1:0] l,
                                                 input logic [CNT_W-1:0] n);
      pad_line = l;
      for (int k = 1; k < BEATS; k++) begin
         if (n == CNT_W'(BEATS - k))
            pad_line = l << (IN_W * k);
      end
   endfunction

   always_comb begin
      in_ready    = (state_reg == FILL) || out_ready;
      accept      = in_valid && in_ready;
      handoff     = (state_reg == HOLD) && out_ready;
      flush_eff   = flush && (state_reg == FILL);
      // A beat accepted during handoff starts a fresh line.
      base_cnt    = (state_reg == HOLD) ? '0 : cnt_reg;
      shifted     = (base_cnt == '0) ? {{(OUT_W-IN_W){1'b0}}, in_data}
                                     : {line_reg[OUT_W-IN_W-1:0], in_data};
      close_beats = base_cnt + 1'b1;

      state_next  = state_reg;
      cnt_next    = cnt_reg;
      line_next   = line_reg;
      last_next   = last_reg;
      beats_next  = beats_reg;

      if (handoff) begin
         state_next = FILL;
         cnt_next   = '0;
      end

      if (accept) begin
         if (base_cnt == LAST_IDX || in_last || flush_eff) begin
            line_next  = pad_line(shifted, close_beats);
            last_next  = in_last || flush_eff;
            beats_next = close_beats;
            cnt_next   = '0;
            state_next = HOLD;
         end else begin
            line_next  = shifted;
            cnt_next   = close_beats;
            state_next = FILL;
         end
      end else if (flush_eff && cnt_reg != '0) begin
         line_next  = pad_line(line_reg, cnt_reg);
         last_next  = 1'b1;
         beats_next = cnt_reg;
         cnt_next   = '0;
         state_next = HOLD;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= FILL;
         cnt_reg   <= '0;
         line_reg  <= '0;
         last_reg  <= 1'b0;
         beats_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         line_reg  <= line_next;
         last_reg  <= last_next;
         beats_reg <= beats_next;
      end
   end

   assign out_valid = (state_reg == HOLD);
   assign out_data  = line_reg;
   assign out_last  = last_reg;
   assign out_beats = beats_reg;
   assign busy      = (cnt_reg != '0) || out_valid;

`ifdef LINE_STATS_EN
   logic [31:0] line_count_reg;
   logic [31:0] pad_count_reg;
   logic [32:0] pad_sum;

   assign pad_sum = {1'b0, pad_count_reg} + 33'(BEATS_C - beats_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_count_reg <= '0;
         pad_count_reg  <= '0;
      end else if (out_valid && out_ready) begin
         if (line_count_reg != 32'hFFFF_FFFF)
            line_count_reg <= line_count_reg + 32'd1;
         pad_count_reg <= pad_sum[32] ? 32'hFFFF_FFFF : pad_sum[31:0];
      end
   end

   assign line_count = line_count_reg;
   assign pad_count  = pad_count_reg;
`endif

endmodule

// File: tb/tb_shift_reg_line_ctrl.sv
// Bench for shift_reg_line_ctrl: beat-queue model checked every cycle plus directed literal checks.
// Define LINE_STATS_EN to also exercise the statistics outputs.
module tb_shift_reg_line_ctrl;

   localparam int IN_W  = 256;
   localparam int BEATS = 2;
   localparam int CNT_W = 5;
   localparam int OUT_W = IN_W * BEATS;

   logic               clk;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [IN_W-1:0]    in_data;
   logic               in_last;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_data;
   logic               out_last;
   logic [CNT_W-1:0]   out_beats;
   logic               busy;
`ifdef LINE_STATS_EN
   logic [31:0]        line_count;
   logic [31:0]        pad_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   shift_reg_line_ctrl #(.IN_W(IN_W), .BEATS(BEATS), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_beats (out_beats),
      .busy      (busy)
`ifdef LINE_STATS_EN
      ,
      .line_count(line_count),
      .pad_count (pad_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [OUT_W-1:0] act,
                        input logic [OUT_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a list of beats for the open line, and at most one closed line awaiting handoff.
   logic [IN_W-1:0]  mdl_q[$];
   bit               mdl_hold = 1'b0;
   logic [OUT_W-1:0] mdl_line = '0;
   bit               mdl_last = 1'b0;
   int               mdl_nb   = 0;
   longint           mdl_lines = 0;
   longint           mdl_pads  = 0;
   bit               m_fill;
   bit               m_acc;

   function automatic void close_line(input bit last);
      mdl_line = '0;
      foreach (mdl_q[i]) mdl_line[OUT_W-1-i*IN_W -: IN_W] = mdl_q[i];
      mdl_nb   = mdl_q.size();
      mdl_last = last;
      mdl_hold = 1'b1;
      mdl_q.delete();
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mdl_q.delete();
         mdl_hold  = 1'b0;
         mdl_line  = '0;
         mdl_last  = 1'b0;
         mdl_nb    = 0;
         mdl_lines = 0;
         mdl_pads  = 0;
      end else begin
         m_fill = !mdl_hold;
         m_acc  = in_valid && (m_fill || out_ready);
         if (mdl_hold && out_ready) begin
            mdl_lines++;
            mdl_pads += BEATS - mdl_nb;
            mdl_hold = 1'b0;
         end
         if (m_acc) begin
            mdl_q.push_back(in_data);
            if (mdl_q.size() == BEATS || in_last || (flush && m_fill))
               close_line(in_last || (flush && m_fill));
         end else if (flush && m_fill && mdl_q.size() > 0) begin
            close_line(1'b1);
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(posedge clk) begin
      #1;
      check("out_valid", {511'b0, out_valid}, {511'b0, mdl_hold});
      check("in_ready", {511'b0, in_ready}, {511'b0, (!mdl_hold || out_ready)});
      check("busy", {511'b0, busy}, {511'b0, (mdl_q.size() != 0 || mdl_hold)});
      if (mdl_hold) begin
         check("out_data", out_data, mdl_line);
         check("out_last", {511'b0, out_last}, {511'b0, mdl_last});
         check("out_beats", OUT_W'(out_beats), OUT_W'(mdl_nb));
      end
`ifdef LINE_STATS_EN
      check("line_count", OUT_W'(line_count), OUT_W'(mdl_lines));
      check("pad_count", OUT_W'(pad_count), OUT_W'(mdl_pads));
`endif
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic beat(input logic [IN_W-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   logic [OUT_W-1:0] exp_line;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst out_valid", {511'b0, out_valid}, '0);
      check("rst in_ready", {511'b0, in_ready}, {511'b0, 1'b1});
      check("rst busy", {511'b0, busy}, '0);
      check("rst out_data", out_data, '0);
      check("rst out_beats", OUT_W'(out_beats), '0);
      reset = 1'b0;
      tick();

      // Two full beats, streaming
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 256'h1;
      tick();
      in_data   = 256'h2;
      tick();
      in_valid  = 1'b0;
      exp_line  = {256'h1, 256'h2};
      check("two-beat data", out_data, exp_line);
      check("two-beat valid", {511'b0, out_valid}, {511'b0, 1'b1});
      check("two-beat beats", OUT_W'(out_beats), OUT_W'(2));
      check("two-beat last", {511'b0, out_last}, '0);
      tick();

      // Single beat closed by in_last
      beat(256'hAA, 1'b1);
      exp_line = {256'hAA, 256'h0};
      check("last1 data", out_data, exp_line);
      check("last1 beats", OUT_W'(out_beats), OUT_W'(1));
      check("last1 last", {511'b0, out_last}, {511'b0, 1'b1});
      tick();

      // Backpressure: held line, waiting third beat, then no-bubble streaming
      out_ready = 1'b0;
      beat(256'h3, 1'b0);
      beat(256'h4, 1'b0);
      in_valid = 1'b1;
      in_data  = 256'h5;
      exp_line = {256'h3, 256'h4};
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp in_ready", {511'b0, in_ready}, '0);
         check("bp data stable", out_data, exp_line);
      end
      out_ready = 1'b1;
      tick();
      check("bp resume busy", {511'b0, busy}, {511'b0, 1'b1});
      in_data = 256'h6;
      tick();
      exp_line = {256'h5, 256'h6};
      check("stream line1", out_data, exp_line);
      in_data = 256'h7;
      tick();
      in_data = 256'h8;
      tick();
      in_valid = 1'b0;
      exp_line = {256'h7, 256'h8};
      check("stream line2", out_data, exp_line);
      tick();

      // Flush of a one-beat partial line, then flush on an empty buffer
      beat(256'h9, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_line = {256'h9, 256'h0};
      check("flush data", out_data, exp_line);
      check("flush last", {511'b0, out_last}, {511'b0, 1'b1});
      check("flush beats", OUT_W'(out_beats), OUT_W'(1));
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("empty flush valid", {511'b0, out_valid}, '0);
      check("empty flush busy", {511'b0, busy}, '0);

      // Asynchronous reset mid-line
      beat(256'hC0, 1'b0);
      check("pre-reset busy", {511'b0, busy}, {511'b0, 1'b1});
      #4;
      reset = 1'b1;
      #1;
      check("async rst valid", {511'b0, out_valid}, '0);
      check("async rst busy", {511'b0, busy}, '0);
      reset = 1'b0;
      beat(256'hC, 1'b0);
      beat(256'hD, 1'b0);
      exp_line = {256'hC, 256'hD};
      check("post-reset line", out_data, exp_line);
      tick();

      // Flush together with a beat; in_last on a full line
      in_valid = 1'b1;
      in_data  = 256'hE;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      exp_line = {256'hE, 256'h0};
      check("flush+beat data", out_data, exp_line);
      check("flush+beat last", {511'b0, out_last}, {511'b0, 1'b1});
      tick();
      beat(256'hF, 1'b0);
      beat(256'h10, 1'b1);
      exp_line = {256'hF, 256'h10};
      check("full last data", out_data, exp_line);
      check("full last flag", {511'b0, out_last}, {511'b0, 1'b1});
      check("full last beats", OUT_W'(out_beats), OUT_W'(2));
      tick();

`ifdef LINE_STATS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = IN_W'(32'h100 + i);
         tick();
      end
      in_data = 256'h1FF;
      in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      check("stats lines", OUT_W'(line_count), OUT_W'(4));
      check("stats pads", OUT_W'(pad_count), OUT_W'(1));
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
